// File: rtl/swt16_pkg.sv
// Shared definitions for the swt16 pipeline control: FSM encoding, default widths
// and the stage indices that hazard handling addresses directly.
package swt16_pkg;

    localparam int DEF_NUM_STAGES    = 5;
    localparam int DEF_REG_IDX_WIDTH = 4;
    localparam int DEF_CNT_WIDTH     = 32;

    localparam int IDX_IF_DC = 0;
    localparam int IDX_DC_EX = 1;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HALTING = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;
    localparam logic [1:0] ST_STEP    = 2'd3;

endpackage

// File: rtl/swt16_hazard_detect.sv
// Combinational load-use and taken-branch detection for the IF_DC / DC_EX pair.
module swt16_hazard_detect #(
    parameter int REG_IDX_WIDTH = 4,
    parameter bit R0_IS_ZERO    = 1'b1
) (
    input  logic                     v_if_dc,
    input  logic                     v_dc_ex,
    input  logic                     set_pc,
    input  logic [REG_IDX_WIDTH-1:0] src1_idx,
    input  logic [REG_IDX_WIDTH-1:0] src2_idx,
    input  logic                     src1_used,
    input  logic                     src2_used,
    input  logic                     ex_load,
    input  logic [REG_IDX_WIDTH-1:0] ex_dst_idx,
    output logic                     lu,
    output logic                     br
);

    logic dst_live;
    logic match1;
    logic match2;

    always_comb begin
        // With a hard-wired r0, a matching index of 0 implies dst == 0 as well,
        // so excluding the destination covers both sources.
        dst_live = !(R0_IS_ZERO && (ex_dst_idx == '0));
        match1   = src1_used && (src1_idx == ex_dst_idx);
        match2   = src2_used && (src2_idx == ex_dst_idx);
        lu       = v_if_dc && v_dc_ex && ex_load && dst_live && (match1 || match2);
        br       = set_pc && v_dc_ex;
    end

endmodule

// File: rtl/swt16_pipe_ctrl.sv
// Pipeline control for the swt16 core: valid chain, hold/flush generation,
// debug halt/step/resume FSM and saturating retired/stall counters.
module swt16_pipe_ctrl
    import swt16_pkg::*;
#(
    parameter int NUM_STAGES    = DEF_NUM_STAGES,
    parameter int REG_IDX_WIDTH = DEF_REG_IDX_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter bit R0_IS_ZERO    = 1'b1,
    parameter bit RESET_HALTED  = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_dbg_halt_req,
    input  logic                     in_dbg_step_req,
    input  logic                     in_dbg_resume_req,
    input  logic                     in_set_pc,
    input  logic [REG_IDX_WIDTH-1:0] in_dc_src1_idx,
    input  logic [REG_IDX_WIDTH-1:0] in_dc_src2_idx,
    input  logic                     in_dc_src1_used,
    input  logic                     in_dc_src2_used,
    input  logic                     in_ex_load,
    input  logic [REG_IDX_WIDTH-1:0] in_ex_res_reg_idx,
    output logic                     out_fetch_en,
    output logic [NUM_STAGES-1:0]    out_hold,
    output logic [NUM_STAGES-1:0]    out_flush,
    output logic [NUM_STAGES-1:0]    out_valid,
    output logic                     out_halted,
    output logic [CNT_WIDTH-1:0]     out_retired_cnt,
    output logic [CNT_WIDTH-1:0]     out_stall_cnt
);

    localparam logic [1:0] RESET_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;

    logic [1:0]            state_q, state_d;
    logic [NUM_STAGES-1:0] v_q, v_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;
    logic                  lu, br, lu_eff, running, halt_entry, fetch_en;
    logic [NUM_STAGES-1:0] hold, flush;

    swt16_hazard_detect #(
        .REG_IDX_WIDTH (REG_IDX_WIDTH),
        .R0_IS_ZERO    (R0_IS_ZERO)
    ) u_hazard (
        .v_if_dc    (v_q[IDX_IF_DC]),
        .v_dc_ex    (v_q[IDX_DC_EX]),
        .set_pc     (in_set_pc),
        .src1_idx   (in_dc_src1_idx),
        .src2_idx   (in_dc_src2_idx),
        .src1_used  (in_dc_src1_used),
        .src2_used  (in_dc_src2_used),
        .ex_load    (in_ex_load),
        .ex_dst_idx (in_ex_res_reg_idx),
        .lu         (lu),
        .br         (br)
    );

    always_comb begin
        running    = (state_q == ST_RUN) || (state_q == ST_STEP);
        lu_eff     = lu && !br;
        halt_entry = (state_q == ST_RUN) && in_dbg_halt_req;

        // A branch in RUN redirects fetch even if the wrong-path instruction stalls.
        fetch_en = running && !lu;
        if (br && (state_q == ST_RUN)) fetch_en = 1'b1;
        if (halt_entry)                fetch_en = 1'b0;

        hold             = '0;
        flush            = '0;
        hold[IDX_IF_DC]  = lu_eff;
        flush[IDX_IF_DC] = br || !running || (halt_entry && !lu_eff);
        flush[IDX_DC_EX] = br || lu_eff;

        v_d[0] = flush[0] ? 1'b0 : (hold[0] ? v_q[0] : fetch_en);
        for (int k = 1; k < NUM_STAGES; k++) begin
            v_d[k] = flush[k] ? 1'b0 : (hold[k] ? v_q[k] : v_q[k-1]);
        end

        state_d = state_q;
        case (state_q)
            ST_RUN:     if (in_dbg_halt_req) state_d = ST_HALTING;
            // Drained once the registers about to be loaded are all empty.
            ST_HALTING: if (v_d == '0) state_d = ST_HALTED;
            ST_HALTED: begin
                if (in_dbg_resume_req)    state_d = ST_RUN;
                else if (in_dbg_step_req) state_d = ST_STEP;
            end
            ST_STEP:    state_d = ST_HALTING;
            default:    state_d = ST_RUN;
        endcase

        retired_d = retired_q;
        if (v_q[NUM_STAGES-1] && (retired_q != '1)) retired_d = retired_q + CNT_WIDTH'(1);
        stall_d = stall_q;
        if (lu_eff && (stall_q != '1)) stall_d = stall_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RESET_STATE;
            v_q       <= '0;
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign out_fetch_en    = fetch_en;
    assign out_hold        = hold;
    assign out_flush       = flush;
    assign out_valid       = v_q;
    assign out_halted      = (state_q == ST_HALTED);
    assign out_retired_cnt = retired_q;
    assign out_stall_cnt   = stall_q;

endmodule
